// File: rtl/memory_access_ws.sv
// MEM pipeline stage with a byte-addressable little-endian data memory and configurable wait
// states. Stalls upstream while an aligned load/store is in flight.
module memory_access_ws #(
    parameter int unsigned NB_DATA     = 32,
    parameter int unsigned NB_ADDR     = 8,
    parameter int unsigned NB_REG      = 5,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_halt,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_mem2reg,
    input  logic               i_regWrite,
    input  logic [NB_REG-1:0]  i_reg2write,
    output logic               o_stall,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_reg_read,
    output logic [NB_DATA-1:0] o_ALUresult,
    output logic [NB_REG-1:0]  o_reg2write,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic               o_misaligned
);

    typedef enum logic {StIdle, StBusy} state_t;

    localparam logic HasWait = (WAIT_CYCLES != 0);

    state_t state_q;
    logic [3:0] cnt_q;

    logic [NB_DATA-1:0] mem [2**NB_ADDR];

    logic               is_mem, req, bad_align, mis_op, aligned_req, commit, do_write;
    logic [NB_ADDR-1:0] widx;
    logic [NB_DATA-1:0] rdata, load_val, wdata;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [3:0]         be;

    assign is_mem      = i_memRead | i_memWrite;
    assign req         = i_valid & is_mem & ~i_halt;
    assign mis_op      = i_valid & is_mem & bad_align;
    assign aligned_req = req & ~bad_align;
    assign widx        = i_result[NB_ADDR+1:2];
    assign rdata       = mem[widx];

    // In BUSY the access finishes even if halt rises; inputs are held by the stall.
    assign commit   = (state_q == StIdle && aligned_req && !HasWait) ||
                      (state_q == StBusy && cnt_q == 4'd1);
    assign do_write = commit & i_memWrite & ~i_memRead;

    assign o_stall = (state_q == StIdle && aligned_req && HasWait) ||
                     (state_q == StBusy && cnt_q != 4'd1);

    always_comb begin
        case (i_width)
            2'b00:   bad_align = 1'b0;
            2'b01:   bad_align = i_result[0];
            2'b10:   bad_align = |i_result[1:0];
            default: bad_align = 1'b1;
        endcase
    end

    always_comb begin
        case (i_result[1:0])
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = i_result[1] ? rdata[31:16] : rdata[15:0];
        case (i_width)
            2'b00:   load_val = i_sign_flag ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            2'b01:   load_val = i_sign_flag ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            default: load_val = rdata;
        endcase
    end

    always_comb begin
        case (i_width)
            2'b00: begin
                be    = 4'b0001 << i_result[1:0];
                wdata = {4{i_data4Mem[7:0]}};
            end
            2'b01: begin
                be    = i_result[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_data4Mem[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = i_data4Mem;
            end
        endcase
    end

    // Reset abandons a pending store; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!i_rst && do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            o_valid      <= 1'b0;
            o_reg_read   <= '0;
            o_ALUresult  <= '0;
            o_reg2write  <= '0;
            o_mem2reg    <= 1'b0;
            o_regWrite   <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            if ((state_q == StIdle && !i_halt && !(aligned_req && HasWait)) || commit) begin
                o_valid      <= i_valid;
                o_ALUresult  <= i_result;
                o_reg2write  <= i_reg2write;
                o_mem2reg    <= i_valid & i_mem2reg;
                o_regWrite   <= i_valid & i_regWrite & ~mis_op;
                o_misaligned <= mis_op;
                o_reg_read   <= (i_valid && i_memRead && !bad_align) ? load_val : '0;
            end
            case (state_q)
                StIdle: begin
                    if (aligned_req && HasWait) begin
                        state_q      <= StBusy;
                        cnt_q        <= 4'(WAIT_CYCLES);
                        // Stall cycles present a bubble to MEM/WB.
                        o_valid      <= 1'b0;
                        o_mem2reg    <= 1'b0;
                        o_regWrite   <= 1'b0;
                        o_misaligned <= 1'b0;
                    end
                end
                default: begin
                    if (cnt_q == 4'd1) begin
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_ws.sv
// Bench for memory_access_ws: directed table, hand-written corner sequences and random ops
// checked against a byte-array reference model.
module tb_memory_access_ws;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rd, wr;
        logic [1:0]  width;
        logic        sign;
        logic [31:0] addr, data;
        logic        regw, m2r;
        logic [4:0]  rdst;
    } op_t;

    typedef struct {
        int          stalls;
        logic        valid;
        logic [31:0] rd_data;
        logic        regw, m2r, mis;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t e;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // DUT A: 2 wait states, 256 words. DUT B: no wait states, 64 words.
    logic        a_valid, a_halt, a_sign, a_rd, a_wr, a_m2r, a_regw;
    logic [31:0] a_result, a_data;
    logic [1:0]  a_width;
    logic [4:0]  a_rdst;
    logic        a_stall, a_ovalid, a_om2r, a_oregw, a_mis;
    logic [31:0] a_rdata, a_alu;
    logic [4:0]  a_ordst;

    logic        b_valid, b_halt, b_sign, b_rd, b_wr, b_m2r, b_regw;
    logic [31:0] b_result, b_data;
    logic [1:0]  b_width;
    logic [4:0]  b_rdst;
    logic        b_stall, b_ovalid, b_om2r, b_oregw, b_mis;
    logic [31:0] b_rdata, b_alu;
    logic [4:0]  b_ordst;

    memory_access_ws #(.NB_DATA(32), .NB_ADDR(8), .NB_REG(5), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .i_rst(rst), .i_valid(a_valid), .i_halt(a_halt), .i_result(a_result),
        .i_data4Mem(a_data), .i_width(a_width), .i_sign_flag(a_sign), .i_memRead(a_rd),
        .i_memWrite(a_wr), .i_mem2reg(a_m2r), .i_regWrite(a_regw), .i_reg2write(a_rdst),
        .o_stall(a_stall), .o_valid(a_ovalid), .o_reg_read(a_rdata), .o_ALUresult(a_alu),
        .o_reg2write(a_ordst), .o_mem2reg(a_om2r), .o_regWrite(a_oregw), .o_misaligned(a_mis)
    );

    memory_access_ws #(.NB_DATA(32), .NB_ADDR(6), .NB_REG(5), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .i_rst(rst), .i_valid(b_valid), .i_halt(b_halt), .i_result(b_result),
        .i_data4Mem(b_data), .i_width(b_width), .i_sign_flag(b_sign), .i_memRead(b_rd),
        .i_memWrite(b_wr), .i_mem2reg(b_m2r), .i_regWrite(b_regw), .i_reg2write(b_rdst),
        .o_stall(b_stall), .o_valid(b_ovalid), .o_reg_read(b_rdata), .o_ALUresult(b_alu),
        .o_reg2write(b_ordst), .o_mem2reg(b_om2r), .o_regWrite(b_oregw), .o_misaligned(b_mis)
    );

    logic [7:0] bytes_a [1024];
    logic [7:0] bytes_b [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: byte-array memory, width as a byte count, alignment as address modulo size.
    function automatic exp_t model(input int which, input op_t o);
        exp_t        e;
        int          size, base, nb, wc;
        logic        mem_op, mis;
        logic [31:0] v;
        nb = (which != 0) ? 256 : 1024;
        wc = (which != 0) ? 0 : 2;
        mem_op = o.valid && (o.rd || o.wr);
        case (o.width)
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        if (size == 0) mis = mem_op;
        else mis = mem_op && ((o.addr % size) != 0);
        e.valid = o.valid;
        e.m2r = o.valid & o.m2r;
        e.regw = o.valid & o.regw & ~mis;
        e.mis = mis;
        e.rd_data = 32'd0;
        e.stalls = (mem_op && !mis) ? wc : 0;
        if (mem_op && !mis) begin
            base = int'(o.addr % nb);
            if (o.rd) begin
                v = 32'd0;
                for (int k = 0; k < size; k++)
                    v |= 32'((which != 0) ? bytes_b[base+k] : bytes_a[base+k]) << (8 * k);
                if (o.sign && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8 * size);
                e.rd_data = v;
            end else begin
                for (int k = 0; k < size; k++) begin
                    if (which != 0) bytes_b[base+k] = o.data[8*k +: 8];
                    else bytes_a[base+k] = o.data[8*k +: 8];
                end
            end
        end
        return e;
    endfunction

    task automatic drive(input int which, input op_t o);
        if (which == 0) begin
            a_valid = o.valid; a_rd = o.rd; a_wr = o.wr; a_width = o.width; a_sign = o.sign;
            a_result = o.addr; a_data = o.data; a_regw = o.regw; a_m2r = o.m2r; a_rdst = o.rdst;
        end else begin
            b_valid = o.valid; b_rd = o.rd; b_wr = o.wr; b_width = o.width; b_sign = o.sign;
            b_result = o.addr; b_data = o.data; b_regw = o.regw; b_m2r = o.m2r; b_rdst = o.rdst;
        end
    endtask

    // Entered at posedge+1; returns at posedge+1 after the commit edge.
    task automatic check_op(input int which, input op_t o, input exp_t e, input string tag);
        int   stalls;
        logic s, tmo;
        drive(which, o);
        stalls = 0;
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            #1;
            s = (which != 0) ? b_stall : a_stall;
            @(posedge clk);
            #1;
            if (!s) begin
                tmo = 1'b0;
                break;
            end
            stalls++;
        end
        chk({tag, ".timeout"}, 32'(tmo), 32'd0);
        chk({tag, ".stalls"}, stalls, e.stalls);
        chk({tag, ".valid"}, 32'((which != 0) ? b_ovalid : a_ovalid), 32'(e.valid));
        chk({tag, ".reg_read"}, (which != 0) ? b_rdata : a_rdata, e.rd_data);
        chk({tag, ".regWrite"}, 32'((which != 0) ? b_oregw : a_oregw), 32'(e.regw));
        chk({tag, ".mem2reg"}, 32'((which != 0) ? b_om2r : a_om2r), 32'(e.m2r));
        chk({tag, ".misaligned"}, 32'((which != 0) ? b_mis : a_mis), 32'(e.mis));
        if (o.valid) begin
            chk({tag, ".ALUresult"}, (which != 0) ? b_alu : a_alu, o.addr);
            chk({tag, ".reg2write"}, 32'((which != 0) ? b_ordst : a_ordst), 32'(o.rdst));
        end
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] w,
                               input logic s, input logic [31:0] addr, input logic [31:0] data);
        op_t o;
        o.valid = 1'b1; o.rd = rd; o.wr = wr; o.width = w; o.sign = s;
        o.addr = addr; o.data = data; o.regw = 1'b1; o.m2r = rd; o.rdst = addr[4:0] ^ 5'h15;
        return o;
    endfunction

    function automatic exp_t ex(input int st, input logic [31:0] d, input logic mis,
                                input logic m2r);
        exp_t e;
        e.stalls = st; e.valid = 1'b1; e.rd_data = d; e.regw = ~mis; e.m2r = m2r; e.mis = mis;
        return e;
    endfunction

    vec_t tbl [$];
    op_t  o, bub;
    exp_t e;

    initial begin
        bub = mk(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        bub.valid = 1'b0;
        drive(0, bub);
        drive(1, bub);
        a_halt = 1'b0;
        b_halt = 1'b0;

        tbl.push_back('{mk(0, 1, 2, 0, 32'd8, 32'h0), ex(2, 32'h0, 0, 0)});
        tbl.push_back('{mk(0, 1, 2, 0, 32'd4, 32'hA5A5_A5A5), ex(2, 32'h0, 0, 0)});
        tbl.push_back('{mk(1, 0, 2, 0, 32'd4, 32'h0), ex(2, 32'hA5A5_A5A5, 0, 1)});
        tbl.push_back('{mk(0, 1, 0, 0, 32'd9, 32'h1234_56FF), ex(2, 32'h0, 0, 0)});
        tbl.push_back('{mk(1, 0, 0, 1, 32'd9, 32'h0), ex(2, 32'hFFFF_FFFF, 0, 1)});
        tbl.push_back('{mk(1, 0, 0, 0, 32'd9, 32'h0), ex(2, 32'h0000_00FF, 0, 1)});
        tbl.push_back('{mk(1, 0, 2, 0, 32'd8, 32'h0), ex(2, 32'h0000_FF00, 0, 1)});
        tbl.push_back('{mk(1, 0, 1, 0, 32'd5, 32'h0), ex(0, 32'h0, 1, 1)});
        tbl.push_back('{mk(0, 1, 2, 0, 32'd6, 32'hDEAD_BEEF), ex(0, 32'h0, 1, 0)});
        tbl.push_back('{mk(1, 0, 2, 0, 32'd4, 32'h0), ex(2, 32'hA5A5_A5A5, 0, 1)});
        tbl.push_back('{mk(1, 0, 3, 0, 32'd0, 32'h0), ex(0, 32'h0, 1, 1)});
        tbl.push_back('{mk(0, 0, 2, 0, 32'h55, 32'h0), ex(0, 32'h0, 0, 0)});
        tbl.push_back('{mk(0, 1, 1, 0, 32'd10, 32'h1234_BEEF), ex(2, 32'h0, 0, 0)});
        tbl.push_back('{mk(1, 0, 1, 1, 32'd10, 32'h0), ex(2, 32'hFFFF_BEEF, 0, 1)});
        tbl.push_back('{mk(1, 0, 2, 0, 32'd8, 32'h0), ex(2, 32'hBEEF_FF00, 0, 1)});
        tbl.push_back('{mk(1, 0, 1, 1, 32'd8, 32'h0), ex(2, 32'hFFFF_FF00, 0, 1)});
        tbl.push_back('{mk(1, 0, 2, 0, 32'h408, 32'h0), ex(2, 32'hBEEF_FF00, 0, 1)});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.stall", 32'(a_stall), 32'd0);
        chk("reset.valid", 32'(a_ovalid), 32'd0);
        chk("reset.reg_read", a_rdata, 32'd0);
        chk("reset.ALUresult", a_alu, 32'd0);
        chk("reset.ctrl", {27'd0, a_ordst} | 32'({a_om2r, a_oregw, a_mis}), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            void'(model(0, tbl[i].op));
            check_op(0, tbl[i].op, tbl[i].e, $sformatf("tbl%0d", i));
        end

        // Misaligned flag drops after one cycle.
        o = mk(1, 0, 2, 0, 32'd2, 32'h0);
        check_op(0, o, model(0, o), "mis_pulse");
        check_op(0, bub, model(0, bub), "mis_drop");

        // Reset during the final BUSY cycle of a store: no write.
        o = mk(0, 1, 2, 0, 32'd16, 32'h1111_1111);
        check_op(0, o, model(0, o), "rst_pre");
        drive(0, mk(0, 1, 2, 0, 32'd16, 32'h1234_5678));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.valid", 32'(a_ovalid), 32'd0);
        chk("rst_mid.ALUresult", a_alu, 32'd0);
        chk("rst_mid.ctrl", 32'({a_om2r, a_oregw, a_mis}), 32'd0);
        rst = 1'b0;
        drive(0, bub);
        @(posedge clk);
        #1;
        o = mk(1, 0, 2, 0, 32'd16, 32'h0);
        check_op(0, o, model(0, o), "rst_post");

        // Halt in IDLE holds outputs with no stall.
        o = mk(1, 0, 2, 0, 32'd4, 32'h0);
        drive(0, o);
        a_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("halt_idle%0d.stall", i), 32'(a_stall), 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("halt_idle%0d.ALUresult", i), a_alu, 32'd16);
            chk($sformatf("halt_idle%0d.valid", i), 32'(a_ovalid), 32'd1);
        end
        a_halt = 1'b0;
        check_op(0, o, model(0, o), "halt_release");

        // Halt raised mid-BUSY: access completes, then the block idles.
        o = mk(1, 0, 2, 0, 32'd8, 32'h0);
        e = model(0, o);
        drive(0, o);
        #1;
        chk("halt_busy.stall0", 32'(a_stall), 32'd1);
        @(posedge clk);
        #1;
        a_halt = 1'b1;
        #1;
        chk("halt_busy.stall1", 32'(a_stall), 32'd1);
        @(posedge clk);
        #1;
        chk("halt_busy.stall2", 32'(a_stall), 32'd0);
        @(posedge clk);
        #1;
        chk("halt_busy.valid", 32'(a_ovalid), 32'd1);
        chk("halt_busy.reg_read", a_rdata, e.rd_data);
        @(posedge clk);
        #1;
        chk("halt_busy.hold", a_rdata, e.rd_data);
        chk("halt_busy.idle_stall", 32'(a_stall), 32'd0);
        a_halt = 1'b0;
        drive(0, bub);
        @(posedge clk);
        #1;

        // Zero wait states and address wrap on the 64-word instance.
        check_op(1, mk(0, 1, 2, 0, 32'h104, 32'hCAFE_F00D), ex(0, 32'h0, 0, 0), "b_store");
        check_op(1, mk(1, 0, 2, 0, 32'h4, 32'h0), ex(0, 32'hCAFE_F00D, 0, 1), "b_load");
        check_op(1, mk(1, 0, 0, 1, 32'h107, 32'h0), ex(0, 32'hFFFF_FFCA, 0, 1), "b_byte");
        drive(1, bub);

        // Random ops over words 0..15, with upper address bits exercising wrap.
        for (int w = 0; w < 16; w++) begin
            o = mk(0, 1, 2, 0, 32'(4 * w), $urandom);
            check_op(0, o, model(0, o), $sformatf("init%0d", w));
        end
        for (int i = 0; i < 80; i++) begin
            o.valid = ($urandom_range(0, 7) != 0);
            o.rd = 1'($urandom);
            o.wr = 1'($urandom);
            o.width = 2'($urandom_range(0, 3));
            o.sign = 1'($urandom);
            o.addr = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 10);
            o.data = $urandom;
            o.regw = 1'($urandom);
            o.m2r = 1'($urandom);
            o.rdst = 5'($urandom);
            check_op(0, o, model(0, o), $sformatf("rnd%0d", i));
        end
        drive(0, bub);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_ws.md
# memory_access_ws

Parametrised MEM pipeline stage with a byte-addressable, little-endian data memory of configurable depth and a configurable number of wait states. It sits between the EX/MEM and MEM/WB pipeline registers. Upstream stalls are generated through `o_stall` while an access is in flight. The block adds byte-lane stores, signed and unsigned sub-word loads, and misaligned-access detection.

## Interface
- `NB_DATA`, 32: datapath width; fixed at 32 for lane logic.
- `NB_ADDR`, 8: word-index bits; memory depth is 2^NB_ADDR words.
- `NB_REG`, 5: register-index width.
- `WAIT_CYCLES`, 2: extra cycles per load/store, 0..15.
- `clk`  in  1  clock; all state changes on its rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  instruction present from EX/MEM.
- `i_halt`  in  1  freeze; no new access is accepted.
- `i_result`  in  NB_DATA  ALU result, used as the byte address for memory ops.
- `i_data4Mem`  in  NB_DATA  store data, right-aligned.
- `i_width`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `i_sign_flag`  in  1  1 = sign-extend loads.
- `i_memRead`, `i_memWrite`, `i_mem2reg`, `i_regWrite`  in  1 each  control bits.
- `i_reg2write`  in  NB_REG  destination register.
- `o_stall`  out  1  combinational; upstream must hold all inputs while high.
- `o_valid`  out  1  MEM/WB entry valid.
- `o_reg_read`  out  NB_DATA  extended load data.
- `o_ALUresult`  out  NB_DATA  registered `i_result`.
- `o_reg2write`  out  NB_REG  registered destination register.
- `o_mem2reg`, `o_regWrite`  out  1 each  registered control bits.
- `o_misaligned`  out  1  one-cycle flag, aligned with `o_valid`.

## Operation
- **Request.** `req = i_valid & (i_memRead | i_memWrite) & ~i_halt`. Read has priority if both read and write are set.
- **Alignment.**
  - Misaligned if half with `addr[0]` = 1, word with `addr[1:0]` ≠ 0, or width 11.
  - A misaligned op gets no wait states and performs no write.
  - It completes in 1 cycle with `o_misaligned` = 1, `o_regWrite` = 0, `o_reg_read` = 0.
- **Address.** Word index is `addr[NB_ADDR+1:2]`. Upper bits are ignored, so out-of-range addresses wrap.
- **Stores.** Byte writes lane `addr[1:0]` from `data[7:0]`. Half writes lanes {2·`addr[1]`, +1} from `data[15:0]`. Word writes all lanes. Unselected lanes are unchanged.
- **Loads.** Select the lane(s) the same way. Sign-extend if `i_sign_flag` = 1, else zero-extend.
- **FSM states.**
  - IDLE:
    - Aligned `req` with `WAIT_CYCLES` > 0 → BUSY, `cnt` ← `WAIT_CYCLES`.
    - Otherwise (non-memory op, bubble, misaligned, `WAIT_CYCLES` = 0) the op completes at this edge.
  - BUSY:
    - `cnt` decrements each cycle.
    - When `cnt` = 1, the edge commits the access (write, or read capture into `o_reg_read`), loads the output registers, and returns to IDLE.
- **Stall.** `o_stall = (IDLE & aligned req & WAIT_CYCLES>0) | (BUSY & cnt≠1)`.
- **Write-once.** The memory write happens only at the commit edge, exactly once per store.
- **Non-memory valid op.** Passes through in 1 cycle: `o_reg_read` = 0, control bits copied.
- **Bubble (`i_valid` = 0) in IDLE.** `o_valid`, `o_regWrite`, `o_mem2reg`, `o_misaligned` = 0.
- **Halt.**
  - In IDLE: output registers hold their values, nothing is accepted, `o_stall` = 0.
  - In BUSY: the in-flight access completes normally, then the block stays in IDLE while halted.
- **Reset.** Reset in any state forces IDLE, `cnt` = 0 and all outputs to 0. A pending store is abandoned with no write. The memory array is not cleared.

## Timing
- **Reset values.** Every output is 0 and the state is IDLE.
- **Latency, aligned load/store.** `WAIT_CYCLES`+1 cycles from presentation to registered output. `o_stall` is high for the first `WAIT_CYCLES` of those cycles.
- **Latency, other ops.** 1 cycle, with no stall.
- **Back-to-back.** A new request may be presented in the cycle after `o_stall` falls; there is no idle gap.
- **`o_misaligned`.** High for exactly 1 cycle per offending op.
- **Read timing.** Memory read is combinational from the held address and sampled at the commit edge. A store followed by a load to the same word returns the new data.

## Test plan
- `WAIT_CYCLES`=2, store word 0xA5A5A5A5 at addr 4, then load word at addr 4 → `o_stall` high 2 cycles per op; `o_reg_read` = 0xA5A5A5A5 on the 3rd edge of the load; the store commits exactly once.
- Store byte 0xFF at addr 9, then:
  - signed byte load at 9 → 0xFFFFFFFF
  - unsigned byte load at 9 → 0x000000FF
  - word load at 8 (prior 0) → 0x0000FF00
- Half load at addr 5, then word store at addr 6 → `o_misaligned` = 1 for 1 cycle each, `o_regWrite` = 0, no stall, memory unchanged.
- Assert `i_rst` during the 2nd BUSY cycle of a word store of 0x12345678 to addr 16 → outputs 0 next edge, state IDLE, word 16 still holds its old value.
- Assert `i_halt` in IDLE with a load pending → no stall, outputs hold; deassert → load proceeds with full latency. Assert `i_halt` mid-BUSY → the access still completes.
- `WAIT_CYCLES`=0: word store then load at addr 0x104 with `NB_ADDR`=6 → no stall; data lands at word index 1 (wrap); load returns it in 1 cycle.
